// File: rtl/mem_responder.sv
// Byte-addressed little-endian RAM slave with req/ack handshake, configurable latency and byte enables.
// Define MEM_RESPONDER_WRAP_EN to wrap byte indices modulo DEPTH_BYTES instead of flagging range errors.
module mem_responder #(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 2048,
  parameter int LATENCY     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_req,
  input  logic                    write_req,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [8*DATA_BYTES-1:0] write_data,
  input  logic [DATA_BYTES-1:0]   byte_en,
  output logic [8*DATA_BYTES-1:0] read_data,
  output logic                    read_ack,
  output logic                    write_ack,
  output logic                    error,
  output logic                    busy
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int IDX_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [ADDR_WIDTH:0] LAST_OFFSET = (ADDR_WIDTH + 1)'(DATA_BYTES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } stateType;

  stateType stateReg, stateNext;
  logic [3:0]            waitCntReg, waitCntNext;
  logic                  isWriteReg;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [DATA_W-1:0]     wdataReg;
  logic [DATA_BYTES-1:0] byteEnReg;
  logic [DATA_W-1:0]     readDataReg, readDataNext;
  logic                  readAckReg, readAckNext;
  logic                  writeAckReg, writeAckNext;
  logic                  errorReg, errorNext;
  logic                  opLatch;
  logic                  memWe;
  logic                  memWrite;
  logic                  outOfRange;

  logic [7:0]            mem [DEPTH_BYTES];
  logic [IDX_W-1:0]      laneIdx [DATA_BYTES];
  logic [DATA_BYTES-1:0] laneWe;
  logic [DATA_W-1:0]     gathered;

`ifdef MEM_RESPONDER_WRAP_EN
  assign outOfRange = 1'b0;
`else
  // Widened by one bit so addresses near the top of the address space cannot wrap into range.
  assign outOfRange = (({1'b0, addrReg} + LAST_OFFSET) >= DEPTH_LIMIT);
`endif

  // A reset edge must never commit a pending write.
  assign memWrite = memWe && reset;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign laneIdx[gi]        = addrReg[IDX_W-1:0] + IDX_W'(gi);
      assign gathered[8*gi +: 8] = mem[laneIdx[gi]];
      assign laneWe[gi]         = memWrite && byteEnReg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (laneWe[i]) begin
        mem[laneIdx[i]] <= wdataReg[8*i +: 8];
      end
    end
  end

  always_comb begin
    stateNext    = stateReg;
    waitCntNext  = waitCntReg;
    opLatch      = 1'b0;
    readAckNext  = 1'b0;
    writeAckNext = 1'b0;
    errorNext    = 1'b0;
    readDataNext = readDataReg;
    memWe        = 1'b0;
    case (stateReg)
      IDLE: begin
        // Ack-high cycle is a turnaround so a still-held request is not reissued.
        if (!readAckReg && !writeAckReg && (read_req || write_req)) begin
          opLatch = 1'b1;
          if (LATENCY > 0) begin
            stateNext   = WAIT;
            waitCntNext = LAT_LOAD;
          end else begin
            stateNext = ACCESS;
          end
        end
      end
      WAIT: begin
        if (waitCntReg == 4'd0) begin
          stateNext = ACCESS;
        end else begin
          waitCntNext = waitCntReg - 4'd1;
        end
      end
      ACCESS: begin
        stateNext = IDLE;
        errorNext = outOfRange;
        if (isWriteReg) begin
          writeAckNext = 1'b1;
          memWe        = !outOfRange;
        end else begin
          readAckNext  = 1'b1;
          readDataNext = outOfRange ? '0 : gathered;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg    <= IDLE;
      waitCntReg  <= 4'd0;
      readDataReg <= '0;
      readAckReg  <= 1'b0;
      writeAckReg <= 1'b0;
      errorReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      waitCntReg  <= waitCntNext;
      readDataReg <= readDataNext;
      readAckReg  <= readAckNext;
      writeAckReg <= writeAckNext;
      errorReg    <= errorNext;
    end
  end

  // Request capture needs no reset; it is only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    if (opLatch) begin
      isWriteReg <= write_req;
      addrReg    <= address;
      wdataReg   <= write_data;
      byteEnReg  <= byte_en;
    end
  end

  assign read_data = readDataReg;
  assign read_ack  = readAckReg;
  assign write_ack = writeAckReg;
  assign error     = errorReg;
  assign busy      = (stateReg != IDLE);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable byte-addressed, little-endian RAM slave serving the core's read_req/write_req ↔ ack memory handshake.
- Replaces the fixed 32-bit, fixed-latency bench memory model.
- Generalises data width, depth and access latency, and adds byte enables, range checking and a busy flag.
- Sits between the ALU memory port and on-chip storage; also usable as a bench memory.

Parameters:
- DATA_BYTES, 4: bytes per access; data ports are 8*DATA_BYTES wide.
- ADDR_WIDTH, 32: address port width.
- DEPTH_BYTES, 2048: storage size in bytes; must be a power of two, ≥ DATA_BYTES.
- LATENCY, 0: wait cycles inserted between acceptance and access/ack (0..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- read_req  in  1  read request; held by requester until read_ack
- write_req  in  1  write request; held until write_ack
- address  in  ADDR_WIDTH  byte address of lowest byte
- write_data  in  8*DATA_BYTES  write word; byte i = bits [8i+7:8i]
- byte_en  in  DATA_BYTES  per-byte write enable
- read_data  out  8*DATA_BYTES  last completed read word
- read_ack  out  1  one-cycle read-completion pulse
- write_ack  out  1  one-cycle write-completion pulse
- error  out  1  one-cycle pulse alongside ack on out-of-range access
- busy  out  1  high while a request is in flight

Behaviour:
- Reset (reset==0 at a clk edge):
  - State → IDLE.
  - read_data, read_ack, write_ack, error and busy → 0.
  - Wait counter → 0.
  - Storage contents are not cleared.
- States:
  - IDLE: accepts a request.
  - WAIT: counts down LATENCY cycles.
  - ACCESS: performs the access and registers the ack.
- Acceptance: at edge N, in IDLE, with read_ack==0 and write_ack==0, and read_req or write_req high:
  - Latch the operation, address, write_data and byte_en.
  - Go to WAIT if LATENCY>0, else to ACCESS.
  - Requests in any other state or cycle are ignored. This gives one turnaround cycle after each ack, so a still-held request is not double-issued.
- Simultaneous read_req and write_req at acceptance: the write is performed; only write_ack pulses.
- WAIT: decrements each edge; moves to ACCESS after exactly LATENCY edges.
- ACCESS → IDLE at edge N+1+LATENCY. At that edge:
  - Read: read_data byte i ← mem[addr+i]; read_ack ← 1.
  - Write: mem[addr+i] ← write_data byte i for each i with byte_en[i]==1; write_ack ← 1.
  - Ack is visible for exactly one cycle; cleared at the next edge.
- busy = (state != IDLE). It is 1 from edge N to edge N+1+LATENCY.
- Unaligned addresses are legal. Bytes addr..addr+DATA_BYTES-1 are accessed independently.
- Range: an access is out of range when addr+DATA_BYTES-1 ≥ DEPTH_BYTES, computed at ADDR_WIDTH+1 bits so there is no overflow.
- read_data holds its value between reads, and is unaffected by writes and by errored accesses (except as stated under Optional Feature).
- Reset during WAIT or ACCESS aborts the operation: no ack, no error, and a pending write is dropped with memory unchanged.

Optional Feature:
- Macro: MEM_RESPONDER_WRAP_EN.
- Defined:
  - Every byte index is (addr+i) mod DEPTH_BYTES.
  - No access is out of range; error is tied to 0.
- Undefined, on an out-of-range access:
  - error pulses with the ack.
  - A read returns read_data = 0.
  - A write modifies no bytes, including in-range ones.

Test Plan:
- Basic write/read, DATA_BYTES=4, DEPTH_BYTES=64, LATENCY=0:
  - Write 0xDEADBEEF to addr 8, byte_en 4'hF, req at edge N → write_ack high only in cycle after N+1, busy high N..N+1.
  - Read addr 8 → read_data 0xDEADBEEF, read_ack 1 cycle, error 0.
- Byte enables:
  - Write 0x11223344 to addr 8 with byte_en 4'b0101 → read addr 8 returns 0xDE22BE44.
  - Write 0x00000000 to addr 12, then read addr 10 → 0x0000DE22.
- Latency and hold:
  - With LATENCY=3, read req at edge N → read_ack at edge N+4 only.
  - Requester holds read_req through the ack cycle → no second ack until one turnaround cycle has passed.
- Simultaneous requests:
  - read_req=write_req=1 with write_data 0xCAFEF00D at addr 0 → write_ack only, read_ack stays 0.
  - Subsequent read of addr 0 returns 0xCAFEF00D.
- Range, macro undefined:
  - Write to addr 62 → error=1 with write_ack, bytes 62/63 unchanged.
  - Read addr 62 → read_data 0, error=1.
- Range, macro defined:
  - Read addr 62 → bytes {mem[1],mem[0],mem[63],mem[62]}, error 0.
- Reset mid-operation:
  - LATENCY=3, write 0x12345678 to addr 4, assert reset for one edge during WAIT → no ack, busy 0 next cycle.
  - Read addr 4 afterwards returns the pre-write value.
